// File: rtl/kernel_nios2_cpu_debug_cmd_sync.sv
`default_nettype none
// ============================================================================
// Module   : kernel_nios2_cpu_debug_cmd_sync
// Purpose  : Carries debug commands from the JTAG clock domain into the CPU
//            clock domain. The update-IR and update-DR strobes are
//            synchronised and edge-detected. Each update-DR loads the shift
//            register word (jdo) and the bound instruction (cmd_ir) into a
//            one-deep pending slot. The CPU side accepts that slot with
//            cmd_ready, which fires a one-hot take_action / take_no_action
//            pulse.
// Ports    : clk, reset_n        - clock, async active-low reset
//            ir_in, sr           - quasi-static JTAG-domain data
//            vs_uir, vs_udr      - async update strobes
//            cmd_ready           - accept the pending command
//            overrun_clr         - clear the sticky error flags
//            jdo, cmd_ir         - captured command word / instruction
//            cmd_valid           - command pending
//            take_action,
//            take_no_action      - one-hot accept pulses
//            overrun, timeout    - sticky error flags
// Options  : KERNEL_NIOS2_DEBUG_CMD_TIMEOUT_EN - when defined, a pending
//            command is dropped after TIMEOUT cycles without accept and the
//            timeout flag is set.
// Revision : 1.0 - initial release
// ============================================================================
module kernel_nios2_cpu_debug_cmd_sync #(
    parameter int DATA_W      = 38,
    parameter int IR_W        = 2,
    parameter int SYNC_STAGES = 2,
    parameter int ACT_BIT     = DATA_W - 3,
    parameter int TIMEOUT     = 1024
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [IR_W-1:0]      ir_in,
    input  logic [DATA_W-1:0]    sr,
    input  logic                 vs_uir,
    input  logic                 vs_udr,
    input  logic                 cmd_ready,
    input  logic                 overrun_clr,
    output logic [DATA_W-1:0]    jdo,
    output logic [IR_W-1:0]      cmd_ir,
    output logic                 cmd_valid,
    output logic [2**IR_W-1:0]   take_action,
    output logic [2**IR_W-1:0]   take_no_action,
    output logic                 overrun,
    output logic                 timeout
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  uir_sync_q, uir_sync_d;
    logic [SYNC_STAGES-1:0]  udr_sync_q, udr_sync_d;
    logic                    uir_prev_q, udr_prev_q;
    logic [SYNC_STAGES-1:0]  fill_q, fill_d;
    logic                    uir_armed_q, uir_armed_d;
    logic                    udr_armed_q, udr_armed_d;
    logic [IR_W-1:0]         ir_shadow_q, ir_shadow_d;
    logic [DATA_W-1:0]       jdo_q, jdo_d;
    logic [IR_W-1:0]         cmd_ir_q, cmd_ir_d;
    logic                    overrun_q, overrun_d;
    logic                    uir_rise, udr_rise;
    logic                    load;
    logic                    overrun_set;
    logic                    timeout_set;

    // fill_q marks when the synchroniser outputs reflect sampled input rather
    // than reset zeros. A strobe must then be seen low before its rises are
    // honoured, so a strobe held high across reset release is ignored.
    always_comb begin
        uir_sync_d  = {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
        udr_sync_d  = {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
        fill_d      = {fill_q[SYNC_STAGES-2:0], 1'b1};
        uir_armed_d = uir_armed_q | (fill_q[SYNC_STAGES-1] & ~uir_sync_q[SYNC_STAGES-1]);
        udr_armed_d = udr_armed_q | (fill_q[SYNC_STAGES-1] & ~udr_sync_q[SYNC_STAGES-1]);
        uir_rise    = uir_armed_q & uir_sync_q[SYNC_STAGES-1] & ~uir_prev_q;
        udr_rise    = udr_armed_q & udr_sync_q[SYNC_STAGES-1] & ~udr_prev_q;
    end

`ifdef KERNEL_NIOS2_DEBUG_CMD_TIMEOUT_EN
    localparam int c_CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic               timeout_q, timeout_d;
    logic               cnt_expired;

    assign cnt_expired = (cnt_q == c_CNT_LAST);
`else
    logic               cnt_expired;

    assign cnt_expired = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        jdo_d          = jdo_q;
        cmd_ir_d       = cmd_ir_q;
        load           = 1'b0;
        overrun_set    = 1'b0;
        timeout_set    = 1'b0;
        take_action    = '0;
        take_no_action = '0;

        // The shadow follows every update-IR, independent of the FSM.
        ir_shadow_d = uir_rise ? ir_in : ir_shadow_q;

        case (state_q)
            ST_IDLE: begin
                if (udr_rise) begin
                    load    = 1'b1;
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (cmd_ready) begin
                    take_action[cmd_ir_q]    = jdo_q[ACT_BIT];
                    take_no_action[cmd_ir_q] = ~jdo_q[ACT_BIT];
                    // The slot frees this cycle, so a coincident update-DR
                    // refills it instead of overrunning.
                    if (udr_rise) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    if (udr_rise) begin
                        overrun_set = 1'b1;
                    end
                    if (cnt_expired) begin
                        timeout_set = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            jdo_d    = sr;
            cmd_ir_d = ir_shadow_q;
        end

        // A set event in the same cycle as a clear wins.
        overrun_d = overrun_set ? 1'b1 : (overrun_clr ? 1'b0 : overrun_q);
    end

`ifdef KERNEL_NIOS2_DEBUG_CMD_TIMEOUT_EN
    always_comb begin
        timeout_d = timeout_set ? 1'b1 : (overrun_clr ? 1'b0 : timeout_q);
        cnt_d     = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (state_q == ST_PENDING && !cmd_ready) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            uir_sync_q  <= '0;
            udr_sync_q  <= '0;
            uir_prev_q  <= 1'b0;
            udr_prev_q  <= 1'b0;
            fill_q      <= '0;
            uir_armed_q <= 1'b0;
            udr_armed_q <= 1'b0;
            ir_shadow_q <= '0;
            jdo_q       <= '0;
            cmd_ir_q    <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            uir_sync_q  <= uir_sync_d;
            udr_sync_q  <= udr_sync_d;
            uir_prev_q  <= uir_sync_q[SYNC_STAGES-1];
            udr_prev_q  <= udr_sync_q[SYNC_STAGES-1];
            fill_q      <= fill_d;
            uir_armed_q <= uir_armed_d;
            udr_armed_q <= udr_armed_d;
            ir_shadow_q <= ir_shadow_d;
            jdo_q       <= jdo_d;
            cmd_ir_q    <= cmd_ir_d;
            overrun_q   <= overrun_d;
        end
    end

    assign jdo       = jdo_q;
    assign cmd_ir    = cmd_ir_q;
    assign cmd_valid = (state_q == ST_PENDING);
    assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_kernel_nios2_cpu_debug_cmd_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_kernel_nios2_cpu_debug_cmd_sync
// Purpose  : Self-checking bench for kernel_nios2_cpu_debug_cmd_sync: reset
//            state, table-driven command vectors, overrun, coincident
//            accept/load, IR isolation while pending, timeout, reset while
//            pending, and randomized transactions against a command model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_kernel_nios2_cpu_debug_cmd_sync;

    localparam int DW  = 38;
    localparam int IRW = 2;
    localparam int S   = 2;
    localparam int ACT = DW - 3;
    localparam int TO  = 8;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [IRW-1:0]  ir_in;
    logic [DW-1:0]   sr;
    logic            vs_uir, vs_udr, cmd_ready, overrun_clr;
    logic [DW-1:0]   jdo;
    logic [IRW-1:0]  cmd_ir;
    logic            cmd_valid;
    logic [3:0]      take_action, take_no_action;
    logic            overrun, timeout;

    int checks   = 0;
    int failures = 0;

    kernel_nios2_cpu_debug_cmd_sync #(
        .DATA_W      (DW),
        .IR_W        (IRW),
        .SYNC_STAGES (S),
        .ACT_BIT     (ACT),
        .TIMEOUT     (TO)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ir_in          (ir_in),
        .sr             (sr),
        .vs_uir         (vs_uir),
        .vs_udr         (vs_udr),
        .cmd_ready      (cmd_ready),
        .overrun_clr    (overrun_clr),
        .jdo            (jdo),
        .cmd_ir         (cmd_ir),
        .cmd_valid      (cmd_valid),
        .take_action    (take_action),
        .take_no_action (take_no_action),
        .overrun        (overrun),
        .timeout        (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IRW-1:0] ir;
        logic           act;
        logic [DW-1:0]  payload;
        logic [3:0]     exp_ta;
        logic [3:0]     exp_tna;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_ir(input logic [IRW-1:0] ir);
        ir_in  = ir;
        vs_uir = 1'b1;
        repeat (S + 1) tick();
        vs_uir = 1'b0;
        tick();
    endtask

    // Raises vs_udr long enough to be captured; optionally checks that the
    // command appears exactly on edge S+1 counting the sampling edge as 1.
    task automatic send_dr(input logic [DW-1:0] d, input bit chk_lat);
        sr     = d;
        vs_udr = 1'b1;
        if (chk_lat) begin
            repeat (S) tick();
            chk("latency_early_valid", cmd_valid, 0);
            tick();
            chk("latency_valid", cmd_valid, 1);
            chk("latency_jdo", jdo, d);
        end else begin
            repeat (S + 1) tick();
        end
        vs_udr = 1'b0;
        tick();
    endtask

    task automatic accept(input logic [3:0] eta, input logic [3:0] etna, input string name);
        cmd_ready = 1'b1;
        #1;
        chk({name, "_take_action"}, take_action, eta);
        chk({name, "_take_no_action"}, take_no_action, etna);
        tick();
        cmd_ready = 1'b0;
        #1;
        chk({name, "_valid_after"}, cmd_valid, 0);
        chk({name, "_takes_after"}, {take_action, take_no_action}, 0);
    endtask

    function automatic logic [3:0] onehot(input logic [IRW-1:0] ir);
        logic [3:0] one;
        one = 4'b0001;
        return one << ir;
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [63:0] tmp;
        tmp = {$urandom, $urandom};
        return tmp[DW-1:0];
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t            tbl [4];
        logic [DW-1:0]   wa, wb, w;
        logic [IRW-1:0]  rir;
        logic            ovr;
        logic            held;

        tbl[0] = '{ir: 2'd2, act: 1'b1, payload: 38'h01_2345_6789, exp_ta: 4'b0100, exp_tna: 4'b0000};
        tbl[1] = '{ir: 2'd2, act: 1'b0, payload: 38'h3F_FFFF_FFFF, exp_ta: 4'b0000, exp_tna: 4'b0100};
        tbl[2] = '{ir: 2'd0, act: 1'b1, payload: 38'h00_0000_0000, exp_ta: 4'b0001, exp_tna: 4'b0000};
        tbl[3] = '{ir: 2'd3, act: 1'b0, payload: 38'h15_A5A5_5A5A, exp_ta: 4'b0000, exp_tna: 4'b1000};

        reset_n = 1'b0; ir_in = '0; sr = '0; vs_uir = 0; vs_udr = 0;
        cmd_ready = 0; overrun_clr = 0;
        repeat (3) tick();
        cmd_ready = 1'b1;
        #1;
        chk("reset_valid", cmd_valid, 0);
        chk("reset_takes", {take_action, take_no_action}, 0);
        chk("reset_jdo", jdo, 0);
        chk("reset_cmd_ir", cmd_ir, 0);
        chk("reset_flags", {overrun, timeout}, 0);
        cmd_ready = 1'b0;
        reset_n = 1'b1;
        repeat (8) tick();

        // Table-driven basic commands
        for (int i = 0; i < 4; i++) begin
            w = tbl[i].payload;
            w[ACT] = tbl[i].act;
            send_ir(tbl[i].ir);
            send_dr(w, 1);
            chk("tbl_cmd_ir", cmd_ir, tbl[i].ir);
            chk("tbl_jdo_hold", jdo, w);
            accept(tbl[i].exp_ta, tbl[i].exp_tna, "tbl");
            chk("tbl_jdo_idle_hold", jdo, w);
        end

        // Overrun: second word dropped while pending
        wa = 38'h2A_1111_2222; wa[ACT] = 1'b1;
        wb = 38'h05_3333_4444; wb[ACT] = 1'b0;
        send_ir(2'd1);
        send_dr(wa, 0);
        send_dr(wb, 0);
        chk("ovr_jdo", jdo, wa);
        chk("ovr_flag", overrun, 1);
        chk("ovr_valid", cmd_valid, 1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("ovr_clr", overrun, 0);
        accept(4'b0010, 4'b0000, "ovr");

        // Update-DR coincident with accept
        wa = 38'h11_0000_00AA; wa[ACT] = 1'b0;
        wb = 38'h22_0000_00BB; wb[ACT] = 1'b1;
        send_ir(2'd3);
        send_dr(wa, 0);
        sr = wb;
        vs_udr = 1'b1;
        repeat (S) tick();
        cmd_ready = 1'b1;
        #1;
        chk("coin_take_action", take_action, 4'b0000);
        chk("coin_take_no_action", take_no_action, 4'b1000);
        tick();
        cmd_ready = 1'b0;
        #1;
        chk("coin_valid", cmd_valid, 1);
        chk("coin_jdo", jdo, wb);
        chk("coin_overrun", overrun, 0);
        chk("coin_takes_off", {take_action, take_no_action}, 0);
        vs_udr = 1'b0;
        tick();
        accept(4'b1000, 4'b0000, "coin2");

        // Update-IR while pending does not disturb cmd_ir
        wa = 38'h0F_0F0F_0F0F; wa[ACT] = 1'b1;
        send_ir(2'd2);
        send_dr(wa, 0);
        send_ir(2'd1);
        chk("uir_pending_cmd_ir", cmd_ir, 2);
        accept(4'b0100, 4'b0000, "uir_pend");
        send_dr(wa, 0);
        chk("uir_next_cmd_ir", cmd_ir, 1);
        accept(4'b0010, 4'b0000, "uir_next");

        // Timeout behaviour
        wa = 38'h1C_DEAD_BEEF;
        sr = wa;
        vs_udr = 1'b1;
        repeat (S + 1) tick();
        vs_udr = 1'b0;
        chk("to_valid_start", cmd_valid, 1);
`ifdef KERNEL_NIOS2_DEBUG_CMD_TIMEOUT_EN
        held = 1'b1;
        for (int i = 1; i < TO; i++) begin
            tick();
            if (!cmd_valid || take_action != 0 || take_no_action != 0) held = 1'b0;
        end
        chk("to_held_until_limit", held, 1);
        tick();
        chk("to_valid_drop", cmd_valid, 0);
        chk("to_flag", timeout, 1);
        chk("to_no_takes", {take_action, take_no_action}, 0);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("to_clr", timeout, 0);
`else
        held = 1'b1;
        for (int i = 0; i < 120; i++) begin
            tick();
            if (!cmd_valid) held = 1'b0;
        end
        chk("no_to_held", held, 1);
        chk("no_to_flag", timeout, 0);
        accept(4'b0010, 4'b0000, "no_to");
`endif

        // Reset while pending, strobe held across release
        wa = 38'h3A_5A5A_A5A5; wa[ACT] = 1'b1;
        send_ir(2'd2);
        send_dr(wa, 0);
        cmd_ready = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("rst_pend_valid", cmd_valid, 0);
        chk("rst_pend_jdo", jdo, 0);
        chk("rst_pend_takes", {take_action, take_no_action}, 0);
        cmd_ready = 1'b0;
        vs_udr = 1'b1;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (10) tick();
        chk("rst_held_strobe_valid", cmd_valid, 0);
        vs_udr = 1'b0;
        repeat (4) tick();
        wb = 38'h04_0000_1234; wb[ACT] = 1'b1;
        send_dr(wb, 1);
        chk("rst_shadow_cleared", cmd_ir, 0);
        accept(4'b0001, 4'b0000, "rst_after");

        // Randomized transactions against a command-slot model
        for (int n = 0; n < 30; n++) begin
            rir = IRW'($urandom_range(0, 3));
            wa  = rand_word();
            send_ir(rir);
            send_dr(wa, 0);
            ovr = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                wb = rand_word();
                send_dr(wb, 0);
                ovr = 1'b1;
            end else begin
                repeat ($urandom_range(0, 3)) tick();
            end
            chk("rnd_valid", cmd_valid, 1);
            chk("rnd_jdo", jdo, wa);
            chk("rnd_cmd_ir", cmd_ir, rir);
            chk("rnd_overrun", overrun, ovr);
            accept(wa[ACT] ? onehot(rir) : 4'b0000,
                   wa[ACT] ? 4'b0000 : onehot(rir), "rnd");
            if (ovr) begin
                overrun_clr = 1'b1;
                tick();
                overrun_clr = 1'b0;
                chk("rnd_overrun_clr", overrun, 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/kernel_nios2_cpu_debug_cmd_sync.md
KERNEL_NIOS2_CPU_DEBUG_CMD_SYNC -- requirements
Module: kernel_nios2_cpu_debug_cmd_sync

Interface
REQ-001 Parameter DATA_W, default 38: width of the debug shift register and of the captured command word.
REQ-002 Parameter IR_W, default 2: width of the debug instruction register; NUM_CMD = 2**IR_W.
REQ-003 Parameter SYNC_STAGES, default 2, legal range 2..4: number of synchroniser flops on each strobe input.
REQ-004 Parameter ACT_BIT, default DATA_W-3: captured word bit that selects action (1) or no-action (0).
REQ-005 Parameter TIMEOUT, default 1024: cycle limit for a pending command; used only when the timeout feature is compiled in.
REQ-006 Port clk, input, 1: the block's only clock; all state changes on the rising edge.
REQ-007 Port reset_n, input, 1: reset, asynchronous assert, active-low.
REQ-008 Port ir_in, input, IR_W: instruction from the JTAG domain, quasi-static around vs_uir.
REQ-009 Port sr, input, DATA_W: shift register from the JTAG domain, quasi-static around vs_udr.
REQ-010 Port vs_uir and vs_udr, inputs, 1 each: asynchronous update-IR and update-DR strobes.
REQ-011 Port cmd_ready, input, 1: the CPU debug logic accepts the pending command.
REQ-012 Port overrun_clr, input, 1: clears the sticky overrun and timeout flags.
REQ-013 Port jdo, output, DATA_W: captured command word.
REQ-014 Port cmd_ir, output, IR_W: instruction bound to jdo.
REQ-015 Port cmd_valid, output, 1: a command is pending.
REQ-016 Port take_action and take_no_action, outputs, NUM_CMD each: one-hot accept pulses.
REQ-017 Ports overrun and timeout, outputs, 1 each: sticky error flags.

Function
REQ-018 vs_uir and vs_udr SHALL each pass through SYNC_STAGES flops; one further flop SHALL give rise detects uir_rise and udr_rise.
REQ-019 On uir_rise, ir_in SHALL be loaded into an internal ir_shadow register, in any state.
REQ-020 FSM states: IDLE and PENDING; cmd_valid = (state==PENDING).
REQ-021 IDLE on udr_rise: jdo<=sr, cmd_ir<=ir_shadow, go to PENDING.
REQ-022 Latency: jdo and cmd_valid update on the edge SYNC_STAGES+1 clocks after the first clk edge that samples vs_udr high.
REQ-023 PENDING with cmd_ready=1 (accept): take_action[cmd_ir] = jdo[ACT_BIT], take_no_action[cmd_ir] = ~jdo[ACT_BIT], combinationally, for exactly that cycle; go to IDLE.
REQ-024 All other take_* bits SHALL be 0; both vectors SHALL be 0 whenever no accept occurs.
REQ-025 PENDING, udr_rise, no accept: new word dropped, jdo held, overrun<=1, stay PENDING.
REQ-026 PENDING, udr_rise and accept in the same cycle: the accept completes, the new word loads, state stays PENDING, overrun unchanged.
REQ-027 A uir_rise while PENDING SHALL NOT change cmd_ir.
REQ-028 overrun_clr=1 SHALL clear overrun and timeout on the next edge; a set event in the same cycle wins.
REQ-029 jdo SHALL hold its value in IDLE; it changes only on a load.

Reset
REQ-030 reset_n low SHALL asynchronously force the state to IDLE and clear the synchroniser flops, ir_shadow, jdo, cmd_ir, overrun, timeout and the timeout counter to 0.
REQ-031 Consequently, during reset cmd_valid, take_action and take_no_action SHALL be 0.
REQ-032 Reset mid-PENDING SHALL discard the command without any take_* pulse.
REQ-033 A strobe already high at reset release SHALL NOT generate a rise.

Configuration
REQ-034 Macro KERNEL_NIOS2_DEBUG_CMD_TIMEOUT_EN defined: a counter SHALL clear on entry to PENDING and increment each PENDING cycle without accept.
REQ-035 When the count reaches TIMEOUT-1 without accept, the next edge SHALL set timeout and return to IDLE with no take_* pulse.
REQ-036 Macro undefined: no counter is built, timeout is tied to 0, and PENDING waits indefinitely.

Verification
REQ-037 Reset release, IR_W=2, ir_in=2 with a vs_uir pulse, then sr bit ACT_BIT=1 with a vs_udr pulse, cmd_ready=1 -> cmd_valid after SYNC_STAGES+1 clocks, take_action=4'b0100 for one cycle, take_no_action=0.
REQ-038 Same sequence with sr bit ACT_BIT=0 -> take_no_action=4'b0100, take_action=0, jdo equals sr.
REQ-039 cmd_ready=0, two vs_udr pulses (sr=A then sr=B) -> jdo=A, overrun=1; overrun_clr pulse -> overrun=0.
REQ-040 udr_rise coincident with cmd_ready=1 -> one take_* pulse for the old word, jdo=new word, cmd_valid stays 1, overrun=0.
REQ-041 Macro defined, TIMEOUT=8, cmd_ready=0 -> cmd_valid falls after 8 PENDING cycles, timeout=1, no pulse; macro undefined -> cmd_valid held for 100+ cycles.
REQ-042 reset_n low while PENDING -> cmd_valid=0 and jdo=0 immediately; vs_udr held high across release -> no command.
